// File: rtl/gray_pkg.sv
// Shared constants for the 3-bit Gray sequence monitor: data width, lap counter
// sizing and the legacy-compatible FSM state encodings.
package gray_pkg;

    localparam int unsigned GRAY_W = 3;
    localparam int unsigned LAP_W  = 4;

    localparam logic [LAP_W-1:0] LAP_MAX = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// Combinational 3-bit Gray-to-binary decoder.
module gray2bin
    import gray_pkg::*;
(
    input  logic [GRAY_W-1:0] i_gray,
    output logic [GRAY_W-1:0] o_bin
);

    assign o_bin[2] = i_gray[2];
    assign o_bin[1] = i_gray[2] ^ i_gray[1];
    assign o_bin[0] = i_gray[2] ^ i_gray[1] ^ i_gray[0];

endmodule

// File: rtl/gray_monitor.sv
// Receiving end of a 3-bit Gray counter: decodes each sample, checks it is a
// legal +1 step (or a repeat), and tracks wraps and illegal steps.
module gray_monitor
    import gray_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Clear,
    input  logic              Valid,
    input  logic [GRAY_W-1:0] Gray,
    output logic [GRAY_W-1:0] Binary,
    output logic              Advance,
    output logic              Overflow,
    output logic [LAP_W-1:0]  Laps,
    output logic              Error
);

    logic [1:0]        r_state;
    logic [GRAY_W-1:0] r_bin;
    logic              r_adv;
    logic              r_ovf;
    logic [LAP_W-1:0]  r_laps;
    logic              r_err;

    logic [GRAY_W-1:0] w_bin;
    logic [GRAY_W-1:0] w_bin_inc;
    logic              w_step;
    logic              w_hold;

    gray2bin u_gray2bin (
        .i_gray (Gray),
        .o_bin  (w_bin)
    );

    assign w_bin_inc = r_bin + GRAY_W'(1);
    assign w_step    = (w_bin == w_bin_inc);
    assign w_hold    = (w_bin == r_bin);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_adv   <= 1'b0;
            r_ovf   <= 1'b0;
            r_laps  <= '0;
            r_err   <= 1'b0;
        end else if (Clear) begin
            r_state <= ST_IDLE;
            r_bin   <= '0;
            r_adv   <= 1'b0;
            r_ovf   <= 1'b0;
            r_laps  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_adv <= 1'b0;
            if (Valid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_bin   <= w_bin;
                        r_adv   <= 1'b1;
                        r_state <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (w_step) begin
                            r_bin <= w_bin;
                            r_adv <= 1'b1;
                            // Stepping from all-ones back to zero is one full lap.
                            if (r_bin == '1) begin
                                r_ovf <= 1'b1;
                                if (r_laps != LAP_MAX) begin
                                    r_laps <= r_laps + LAP_W'(1);
                                end
                            end
                        end else if (!w_hold) begin
                            r_err   <= 1'b1;
                            r_state <= ST_FAULT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Binary   = r_bin;
    assign Advance  = r_adv;
    assign Overflow = r_ovf;
    assign Laps     = r_laps;
    assign Error    = r_err;

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: stimulus queues hand-computed expectations,
// a monitor pops and compares them on the falling edge after each sample.
module tb_gray_monitor;

    logic       Clk;
    logic       Reset_n;
    logic       Clear;
    logic       Valid;
    logic [2:0] Gray;
    logic [2:0] Binary;
    logic       Advance;
    logic       Overflow;
    logic [3:0] Laps;
    logic       Error;

    typedef struct {
        string      name;
        logic [2:0] bin;
        logic       adv;
        logic       ovf;
        logic [3:0] laps;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    gray_monitor dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Clear    (Clear),
        .Valid    (Valid),
        .Gray     (Gray),
        .Binary   (Binary),
        .Advance  (Advance),
        .Overflow (Overflow),
        .Laps     (Laps),
        .Error    (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input exp_t e);
        n_checks++;
        if ({Binary, Advance, Overflow, Laps, Error} !== {e.bin, e.adv, e.ovf, e.laps, e.err}) begin
            n_errors++;
            $display("FAIL %s: got bin=%0d adv=%0d ovf=%0d laps=%0d err=%0d, want bin=%0d adv=%0d ovf=%0d laps=%0d err=%0d",
                     e.name, Binary, Advance, Overflow, Laps, Error,
                     e.bin, e.adv, e.ovf, e.laps, e.err);
        end
    endtask

    // Call at/after a falling edge; applies inputs, lets one rising edge pass,
    // queues the expected outputs, returns at the next falling edge.
    task automatic drive(input string name, input logic c, input logic v, input logic [2:0] g,
                         input logic [2:0] eb, input logic ea, input logic eo,
                         input logic [3:0] el, input logic ee);
        exp_t e;
        Clear = c;
        Valid = v;
        Gray  = g;
        @(posedge Clk);
        e.name = name; e.bin = eb; e.adv = ea; e.ovf = eo; e.laps = el; e.err = ee;
        q.push_back(e);
        @(negedge Clk);
    endtask

    initial begin : monitor
        forever begin
            @(negedge Clk);
            if (q.size() > 0) check(q.pop_front());
        end
    end

    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    initial begin : stim
        exp_t z;
        z.bin = 3'd0; z.adv = 1'b0; z.ovf = 1'b0; z.laps = 4'd0; z.err = 1'b0;

        Reset_n = 1'b0; Clear = 1'b0; Valid = 1'b0; Gray = 3'b000;
        #3;
        z.name = "reset_state";
        check(z);

        // Release with Valid already high: first edge is the IDLE start.
        @(negedge Clk);
        Reset_n = 1'b1;
        drive("seq_0", 0, 1, 3'b000, 3'd0, 1, 0, 4'd0, 0);
        drive("seq_1", 0, 1, 3'b001, 3'd1, 1, 0, 4'd0, 0);
        drive("seq_2", 0, 1, 3'b011, 3'd2, 1, 0, 4'd0, 0);
        drive("seq_3", 0, 1, 3'b010, 3'd3, 1, 0, 4'd0, 0);
        drive("seq_4", 0, 1, 3'b110, 3'd4, 1, 0, 4'd0, 0);
        drive("seq_5", 0, 1, 3'b111, 3'd5, 1, 0, 4'd0, 0);
        drive("seq_6", 0, 1, 3'b101, 3'd6, 1, 0, 4'd0, 0);
        drive("seq_7", 0, 1, 3'b100, 3'd7, 1, 0, 4'd0, 0);
        drive("seq_wrap", 0, 1, 3'b000, 3'd0, 1, 1, 4'd1, 0);
        drive("idle_gap", 0, 0, 3'b011, 3'd0, 0, 1, 4'd1, 0);

        // Repeats hold without error.
        drive("clr_a", 1, 0, 3'b000, 3'd0, 0, 0, 4'd0, 0);
        drive("rep_s0", 0, 1, 3'b000, 3'd0, 1, 0, 4'd0, 0);
        drive("rep_s1", 0, 1, 3'b001, 3'd1, 1, 0, 4'd0, 0);
        drive("rep_s2", 0, 1, 3'b011, 3'd2, 1, 0, 4'd0, 0);
        drive("rep_h1", 0, 1, 3'b011, 3'd2, 0, 0, 4'd0, 0);
        drive("rep_h2", 0, 1, 3'b011, 3'd2, 0, 0, 4'd0, 0);
        drive("rep_h3", 0, 1, 3'b011, 3'd2, 0, 0, 4'd0, 0);
        drive("rep_step", 0, 1, 3'b010, 3'd3, 1, 0, 4'd0, 0);
        drive("rep_novalid", 0, 0, 3'b110, 3'd3, 0, 0, 4'd0, 0);

        // Illegal jump 1 -> 4 faults; later samples ignored.
        drive("clr_b", 1, 0, 3'b000, 3'd0, 0, 0, 4'd0, 0);
        drive("flt_s0", 0, 1, 3'b000, 3'd0, 1, 0, 4'd0, 0);
        drive("flt_s1", 0, 1, 3'b001, 3'd1, 1, 0, 4'd0, 0);
        drive("flt_bad", 0, 1, 3'b110, 3'd1, 0, 0, 4'd0, 1);
        drive("flt_ign", 0, 1, 3'b011, 3'd1, 0, 0, 4'd0, 1);

        // Clear beats Valid; then a fresh start at an arbitrary value.
        drive("clr_prio", 1, 1, 3'b001, 3'd0, 0, 0, 4'd0, 0);
        drive("restart", 0, 1, 3'b111, 3'd5, 1, 0, 4'd0, 0);

        // 17 laps: counter saturates at 15.
        drive("clr_c", 1, 0, 3'b000, 3'd0, 0, 0, 4'd0, 0);
        drive("lap_start", 0, 1, 3'b000, 3'd0, 1, 0, 4'd0, 0);
        for (int k = 1; k <= 17; k++) begin
            for (int j = 1; j <= 8; j++) begin
                logic [3:0] el;
                logic [2:0] eb;
                int done;
                done = (j == 8) ? k : k - 1;
                el = (done > 15) ? 4'd15 : 4'(done);
                eb = 3'(j % 8);
                drive($sformatf("lap%0d_%0d", k, j), 0, 1, gseq[j % 8], eb, 1, (done > 0), el, 0);
            end
        end

        // Asynchronous reset between edges with Binary=6.
        drive("clr_d", 1, 0, 3'b000, 3'd0, 0, 0, 4'd0, 0);
        for (int j = 0; j <= 6; j++)
            drive($sformatf("pre_rst_%0d", j), 0, 1, gseq[j], 3'(j), 1, 0, 4'd0, 0);
        Valid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        z.name = "async_reset";
        check(z);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        drive("post_rst_idle", 0, 0, 3'b000, 3'd0, 0, 0, 4'd0, 0);
        drive("post_rst_start", 0, 1, 3'b010, 3'd3, 1, 0, 4'd0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Clk);
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 Parameters: none. Width is fixed at 3 bits, matching the 3-bit Gray counter.
REQ-002 Clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 Reset_n  input  1  Asynchronous, active-low reset.
REQ-004 Clear  input  1  Synchronous clear of the error/overflow/lap state and return to IDLE.
REQ-005 Valid  input  1  Gray is a sample to be checked this cycle.
REQ-006 Gray  input  3  Incoming 3-bit Gray code sample.
REQ-007 Binary  output  3  Registered binary value of the last accepted sample.
REQ-008 Advance  output  1  One-cycle pulse: the last accepted sample was a legal +1 step or the first sample.
REQ-009 Overflow  output  1  Sticky: a wrap 3'b100 -> 3'b000 was accepted.
REQ-010 Laps  output  4  Count of accepted wraps, saturating.
REQ-011 Error  output  1  Sticky: an illegal step was seen.

Function
REQ-012 The block SHALL be the receiving end of the 3-bit Gray counter: it decodes and checks the sequence 000,001,011,010,110,111,101,100,000.
REQ-013 Decoding SHALL be standard Gray-to-binary: b2=g2, b1=g2^g1, b0=g2^g1^g0.
REQ-014 The FSM SHALL have states IDLE, TRACK, FAULT; reset state is IDLE.
REQ-015 IDLE, Valid=1: Binary <= decode(Gray), Advance <= 1, next state TRACK; any start value is legal.
REQ-016 TRACK, Valid=1, decode(Gray) == Binary+1 mod 8: Binary updates, Advance <= 1.
REQ-017 TRACK, Valid=1, decode(Gray) == Binary: hold. No update, Advance <= 0, not an error.
REQ-018 TRACK, Valid=1, any other value: Error <= 1, next state FAULT, Binary holds, Advance <= 0.
REQ-019 A legal step from Binary=7 to 0 SHALL set Overflow <= 1 and increment Laps; Laps saturates at 15.
REQ-020 FAULT SHALL ignore Valid/Gray; Binary, Laps and Overflow hold; exit only via Clear or reset.
REQ-021 Valid=0 in any state: no state change, Advance <= 0.
REQ-022 Clear=1 SHALL take priority over Valid in the same cycle: the sample is discarded; next state IDLE; Error, Overflow, Advance <= 0; Laps <= 0; Binary <= 0.
REQ-023 Latency: outputs reflect a sample on the rising edge after Valid; one sample per cycle is accepted at full rate.
REQ-024 All outputs SHALL be registered; none depend combinationally on inputs.

Reset
REQ-025 Reset_n=0 SHALL immediately force state IDLE, Binary=0, Advance=0, Overflow=0, Laps=0, Error=0, regardless of Clk.
REQ-026 Reset asserted mid-sequence or in FAULT SHALL discard all tracking history; the first valid sample after release is treated as a start.
REQ-027 Deassertion SHALL be safe with Valid=1 on the first edge; that sample is taken as the IDLE start.

Structure
REQ-028 Shared package gray_pkg SHALL hold the width constant (3), the FSM state encodings, and the lap-counter width/saturation constant.
REQ-029 A combinational sub-module gray2bin (3-bit in, 3-bit out) SHALL perform the decode; the top instantiates it once on Gray.
REQ-030 The top SHALL hold the FSM, the step comparator, and the output registers; expected size is 120-250 lines of RTL.

Verification
REQ-031 Reset, then Valid every cycle with Gray 000,001,011,010,110,111,101,100,000 -> Binary 0..7,0; Advance=1 each cycle; Overflow=1 and Laps=1 after the last sample; Error=0.
REQ-032 In TRACK at Binary=2 (Gray 011), apply Gray 011 three times, then 010 -> Binary stays 2 (Advance=0) during the repeats, then becomes 3 with Advance=1; Error=0.
REQ-033 In TRACK at Binary=1, apply Gray 110 (decode 4) -> Error=1, state FAULT, Binary=1; a following Gray 011 is ignored.
REQ-034 In FAULT, assert Clear together with Valid and Gray 001 -> Error=0, Binary=0, Laps=0, IDLE; the next Valid with Gray 111 gives Binary=5 and Advance=1.
REQ-035 Run 17 full cycles of the sequence -> Laps saturates at 15 and Overflow=1.
REQ-036 Assert Reset_n=0 between clock edges with Binary=6 -> all outputs 0 immediately; after release, first Valid with Gray 010 gives Binary=3 and Error=0.
